// File: rtl/ps2_key_rx_if.sv
// Decoded-key event bundle between the PS/2 receiver (master) and game input logic (slave).
interface ps2_key_rx_if #(
    parameter int NUM_KEYS = 8
);
    logic [NUM_KEYS-1:0] keys;
    logic                code_valid;
    logic [7:0]          code;
    logic                code_ext;
    logic                code_brk;
    logic                frame_err;

    modport master (
        output keys, code_valid, code, code_ext, code_brk, frame_err
    );

    modport slave (
        input keys, code_valid, code, code_ext, code_brk, frame_err
    );
endinterface

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: deglitch, deframe, E0/F0 prefix tracking, per-key held bits.
// Optional build macro PS2_PARITY_CHECK_EN makes odd-parity mismatches fail the frame.
module ps2_key_rx #(
    parameter int NUM_KEYS    = 8,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000,
    parameter logic [NUM_KEYS*9-1:0] KEY_CODES = {9'h11D, 9'h114, 9'h029, 9'h02D,
                                                  9'h01D, 9'h023, 9'h01C, 9'h01B}
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    ps2_key_rx_if.master  evt
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;

    function automatic logic odd_parity_ok(input logic [8:0] v);
        return ^v;
    endfunction

    logic [1:0]            clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
    logic [FILTER_LEN-1:0] clk_shr_q, clk_shr_d, data_shr_q, data_shr_d;
    logic                  clk_filt_q, clk_filt_d, data_filt_q, data_filt_d;
    logic                  clk_prev_q, clk_prev_d;
    logic                  fall_s, tmo_s, par_ok_s;
    state_t                state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic [TW-1:0]         to_cnt_q, to_cnt_d;
    logic                  ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
    logic [NUM_KEYS-1:0]   keys_q, keys_d;
    logic [7:0]            code_q, code_d;
    logic                  code_ext_q, code_ext_d, code_brk_q, code_brk_d;
    logic                  code_valid_q, code_valid_d, frame_err_q, frame_err_d;
`ifdef PS2_PARITY_CHECK_EN
    logic                  par_q, par_d;
`endif

    // Synchronise both pins, then require FILTER_LEN agreeing samples before the level moves.
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        clk_shr_d   = {clk_shr_q[FILTER_LEN-2:0], clk_sync_q[1]};
        data_shr_d  = {data_shr_q[FILTER_LEN-2:0], data_sync_q[1]};
        clk_prev_d  = clk_filt_q;
        if (&clk_shr_d)       clk_filt_d = 1'b1;
        else if (~|clk_shr_d) clk_filt_d = 1'b0;
        else                  clk_filt_d = clk_filt_q;
        if (&data_shr_d)       data_filt_d = 1'b1;
        else if (~|data_shr_d) data_filt_d = 1'b0;
        else                   data_filt_d = data_filt_q;
    end

    assign fall_s = clk_prev_q & ~clk_filt_q;
    assign tmo_s  = (state_q != IDLE) && (to_cnt_q == TMO_LAST);

`ifdef PS2_PARITY_CHECK_EN
    assign par_ok_s = odd_parity_ok({shift_q, par_q});
`else
    assign par_ok_s = 1'b1;
`endif

    // Deframing FSM, timeout, prefix tracking and key table update.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        ext_pend_d   = ext_pend_q;
        brk_pend_d   = brk_pend_q;
        keys_d       = keys_q;
        code_d       = code_q;
        code_ext_d   = code_ext_q;
        code_brk_d   = code_brk_q;
        code_valid_d = 1'b0;
        frame_err_d  = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        par_d        = par_q;
`endif
        if ((state_q == IDLE) || fall_s) to_cnt_d = {TW{1'b0}};
        else                             to_cnt_d = to_cnt_q + TW'(1);

        // The timeout takes priority over a coincident falling edge.
        if (tmo_s) begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
            ext_pend_d  = 1'b0;
            brk_pend_d  = 1'b0;
            to_cnt_d    = {TW{1'b0}};
        end else if (fall_s) begin
            case (state_q)
                IDLE: begin
                    if (!data_filt_q) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                DATA: begin
                    shift_d   = {data_filt_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                    else                   state_d = DATA;
                end
                PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    par_d = data_filt_q;
`endif
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (data_filt_q && par_ok_s) begin
                        if (shift_q == 8'hE0) begin
                            ext_pend_d = 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            brk_pend_d = 1'b1;
                        end else begin
                            code_d       = shift_q;
                            code_ext_d   = ext_pend_q;
                            code_brk_d   = brk_pend_q;
                            code_valid_d = 1'b1;
                            ext_pend_d   = 1'b0;
                            brk_pend_d   = 1'b0;
                            for (int i = 0; i < NUM_KEYS; i++) begin
                                if (KEY_CODES[i*9 +: 9] == {ext_pend_q, shift_q}) keys_d[i] = !brk_pend_q;
                                else                                              keys_d[i] = keys_q[i];
                            end
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        ext_pend_d  = 1'b0;
                        brk_pend_d  = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers; lines idle high after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q   <= 2'b11;
            data_sync_q  <= 2'b11;
            clk_shr_q    <= {FILTER_LEN{1'b1}};
            data_shr_q   <= {FILTER_LEN{1'b1}};
            clk_filt_q   <= 1'b1;
            data_filt_q  <= 1'b1;
            clk_prev_q   <= 1'b1;
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            to_cnt_q     <= {TW{1'b0}};
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            keys_q       <= {NUM_KEYS{1'b0}};
            code_q       <= 8'h00;
            code_ext_q   <= 1'b0;
            code_brk_q   <= 1'b0;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par_q        <= 1'b0;
`endif
        end else begin
            clk_sync_q   <= clk_sync_d;
            data_sync_q  <= data_sync_d;
            clk_shr_q    <= clk_shr_d;
            data_shr_q   <= data_shr_d;
            clk_filt_q   <= clk_filt_d;
            data_filt_q  <= data_filt_d;
            clk_prev_q   <= clk_prev_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            to_cnt_q     <= to_cnt_d;
            ext_pend_q   <= ext_pend_d;
            brk_pend_q   <= brk_pend_d;
            keys_q       <= keys_d;
            code_q       <= code_d;
            code_ext_q   <= code_ext_d;
            code_brk_q   <= code_brk_d;
            code_valid_q <= code_valid_d;
            frame_err_q  <= frame_err_d;
`ifdef PS2_PARITY_CHECK_EN
            par_q        <= par_d;
`endif
        end
    end

    assign evt.keys       = keys_q;
    assign evt.code       = code_q;
    assign evt.code_ext   = code_ext_q;
    assign evt.code_brk   = code_brk_q;
    assign evt.code_valid = code_valid_q;
    assign evt.frame_err  = frame_err_q;
endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed bench for ps2_key_rx: frames driven on the pins, outputs checked against hand values.
module tb_ps2_key_rx;
    localparam int TMO = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cv_cnt = 0;
    int   fe_cnt = 0;
    int   cv0, fe0;
    logic [7:0] exp_keys;

    ps2_key_rx_if #(.NUM_KEYS(8)) evt ();

    ps2_key_rx #(.NUM_KEYS(8), .FILTER_LEN(8), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .evt(evt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && evt.code_valid) cv_cnt <= cv_cnt + 1;
        if (!rst && evt.frame_err)  fe_cnt <= fe_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        cyc(15);
        ps2_clk = 1'b0;
        cyc(30);
        ps2_clk = 1'b1;
        cyc(15);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ flip_par);
        send_bit(1'b1);
        cyc(10);
    endtask

    initial begin
        cyc(5);
        check_eq("rst_keys", {24'd0, evt.keys}, 32'd0);
        check_eq("rst_code", {24'd0, evt.code}, 32'd0);
        check_eq("rst_flags", {28'd0, evt.code_ext, evt.code_brk, evt.code_valid, evt.frame_err}, 32'd0);
        rst = 1'b0;
        cyc(20);

        // make then break of key 0
        cv0 = cv_cnt;
        send_frame(8'h1B, 1'b0);
        check_eq("make1b_keys", {24'd0, evt.keys}, 32'h01);
        check_eq("make1b_code", {23'd0, evt.code_brk, evt.code}, 32'h01B);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1B, 1'b0);
        check_eq("brk1b_keys", {24'd0, evt.keys}, 32'h00);
        check_eq("brk1b_code", {23'd0, evt.code_brk, evt.code}, 32'h11B);
        check_eq("brk1b_cvcnt", cv_cnt - cv0, 32'd2);

        // extended versus plain
        send_frame(8'hE0, 1'b0);
        send_frame(8'h1D, 1'b0);
        check_eq("ext1d_keys", {24'd0, evt.keys}, 32'h80);
        check_eq("ext1d_ext", {31'd0, evt.code_ext}, 32'd1);
        send_frame(8'h1D, 1'b0);
        check_eq("pl1d_keys", {24'd0, evt.keys}, 32'h88);
        check_eq("pl1d_ext", {31'd0, evt.code_ext}, 32'd0);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1D, 1'b0);
        check_eq("extbrk_keys", {24'd0, evt.keys}, 32'h08);
        check_eq("extbrk_flags", {30'd0, evt.code_ext, evt.code_brk}, 32'd3);

        // bad parity on 1C
        fe0 = fe_cnt;
        send_frame(8'h1C, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        exp_keys = 8'h08;
        check_eq("par_fe", fe_cnt - fe0, 32'd1);
        check_eq("par_code", {24'd0, evt.code}, 32'h1D);
`else
        exp_keys = 8'h0A;
        check_eq("par_fe", fe_cnt - fe0, 32'd0);
        check_eq("par_code", {24'd0, evt.code}, 32'h1C);
`endif
        check_eq("par_keys", {24'd0, evt.keys}, {24'd0, exp_keys});

        // timeout mid-frame
        fe0 = fe_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        ps2_data = 1'b1;
        cyc(TMO + 10);
        check_eq("tmo_fe", fe_cnt - fe0, 32'd1);
        send_frame(8'h23, 1'b0);
        exp_keys = exp_keys | 8'h04;
        check_eq("tmo_next_keys", {24'd0, evt.keys}, {24'd0, exp_keys});
        check_eq("tmo_next_code", {22'd0, evt.code_ext, evt.code_brk, evt.code}, 32'h023);

        // glitch rejection
        fe0 = fe_cnt;
        cv0 = cv_cnt;
        ps2_data = 1'b0;
        for (int g = 0; g < 5; g++) begin
            ps2_clk = 1'b0;
            cyc(3);
            ps2_clk = 1'b1;
            cyc(20);
        end
        ps2_data = 1'b1;
        cyc(TMO + 10);
        check_eq("glitch_fe", fe_cnt - fe0, 32'd0);
        check_eq("glitch_cv", cv_cnt - cv0, 32'd0);
        send_frame(8'h29, 1'b0);
        exp_keys = exp_keys | 8'h20;
        check_eq("glitch_next_keys", {24'd0, evt.keys}, {24'd0, exp_keys});
        check_eq("glitch_next_code", {24'd0, evt.code}, 32'h29);

        // reset between F0 and 2D
        send_frame(8'h2D, 1'b0);
        exp_keys = exp_keys | 8'h10;
        check_eq("mk2d_keys", {24'd0, evt.keys}, {24'd0, exp_keys});
        send_frame(8'hF0, 1'b0);
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(3);
        check_eq("rst2_keys", {24'd0, evt.keys}, 32'd0);
        check_eq("rst2_code", {24'd0, evt.code}, 32'd0);
        check_eq("rst2_flags", {28'd0, evt.code_ext, evt.code_brk, evt.code_valid, evt.frame_err}, 32'd0);
        send_frame(8'h2D, 1'b0);
        check_eq("post_rst_keys", {24'd0, evt.keys}, 32'h10);
        check_eq("post_rst_code", {23'd0, evt.code_brk, evt.code}, 32'h02D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
